// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
// Target side of the CPU memory bus. Owns the mirrored work RAM, fronts the
// cartridge PRG ROM, bridges PPU register accesses through a req/ack port and
// runs the $4014 OAM DMA engine that copies one 256-byte page to PPU reg 4.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_cpu_addr/write/d_out    CPU bus request (held while o_cpu_ready=0)
//   o_cpu_d_in                read data, one cycle after the address
//   o_cpu_ready               0 = CPU must hold and not advance
//   o_prg_addr, i_prg_data    PRG ROM port, data one cycle after address
//   o_ppu_req/we/reg/wdata    PPU register access, held until i_ppu_ack
//   i_ppu_ack, i_ppu_rdata    PPU completion and read data
//
// State table
//   S_IDLE      | servicing CPU bus directly; RAM/PRG/open bus in one cycle
//   S_PPU_WAIT  | PPU request outstanding, CPU stalled
//   S_PPU_DONE  | PPU access complete, CPU released, captured data loads next
//   S_DMA_ALIGN | dummy cycle(s) before the first DMA read
//   S_DMA_READ  | fetch byte {page, cnt}
//   S_DMA_WRITE | write fetched byte to OAM data register, wait for ack
module cpu_bus_responder #(
    parameter int         RAM_AW       = 11,
    parameter logic [15:0] DMA_ADDR     = 16'h4014,
    parameter logic [2:0]  OAM_DATA_REG = 3'd4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_write,
    input  logic [7:0]  i_cpu_d_out,
    output logic [7:0]  o_cpu_d_in,
    output logic        o_cpu_ready,
    output logic [14:0] o_prg_addr,
    input  logic [7:0]  i_prg_data,
    output logic        o_ppu_req,
    output logic        o_ppu_we,
    output logic [2:0]  o_ppu_reg,
    output logic [7:0]  o_ppu_wdata,
    input  logic        i_ppu_ack,
    input  logic [7:0]  i_ppu_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_PPU_WAIT, S_PPU_DONE, S_DMA_ALIGN, S_DMA_READ, S_DMA_WRITE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_d_in;
    logic        r_prg_pend;
    logic [7:0]  r_ppu_rd;
    logic        r_ppu_is_read;
    logic [7:0]  r_page;
    logic [7:0]  r_cnt;
    logic        r_parity;
    logic        r_align_cnt;
    logic [7:0]  r_dma_byte;
    logic        r_dma_prg;
    logic [7:0]  r_ram [2**RAM_AW];

    logic              w_cpu_ram;
    logic              w_cpu_ppu;
    logic              w_cpu_prg;
    logic [15:0]       w_dma_addr;
    logic              w_dma_ram;
    logic              w_dma_prg;
    logic [RAM_AW-1:0] w_ram_addr;
    logic              w_ram_we;
    logic [7:0]        w_dma_data;

    assign w_cpu_ram  = (i_cpu_addr[15:13] == 3'b000);
    assign w_cpu_ppu  = (i_cpu_addr[15:13] == 3'b001);
    assign w_cpu_prg  = i_cpu_addr[15];
    assign w_dma_addr = {r_page, r_cnt};
    assign w_dma_ram  = (w_dma_addr[15:13] == 3'b000);
    assign w_dma_prg  = w_dma_addr[15];
    assign w_ram_addr = (r_state == S_DMA_READ) ? w_dma_addr[RAM_AW-1:0]
                                                : i_cpu_addr[RAM_AW-1:0];
    // CPU writes land only from IDLE, so DMA locks the CPU out of RAM.
    assign w_ram_we   = !i_reset && (r_state == S_IDLE) && i_cpu_write && w_cpu_ram;
    // PRG data for a DMA byte arrives during DMA_WRITE; prg_addr is held there.
    assign w_dma_data = r_dma_prg ? i_prg_data : r_dma_byte;

    always_ff @(posedge i_clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_addr] <= i_cpu_d_out;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_d_in        <= 8'h00;
            r_prg_pend    <= 1'b0;
            r_ppu_rd      <= 8'h00;
            r_ppu_is_read <= 1'b0;
            r_page        <= 8'h00;
            r_cnt         <= 8'h00;
            r_parity      <= 1'b0;
            r_align_cnt   <= 1'b0;
            r_dma_byte    <= 8'h00;
            r_dma_prg     <= 1'b0;
        end else begin
            r_parity   <= ~r_parity;
            r_prg_pend <= 1'b0;
            // A PRG read shows live ROM data for one cycle, then is latched as open bus.
            if (r_prg_pend) begin
                r_d_in <= i_prg_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_cpu_ppu) begin
                        r_state <= S_PPU_WAIT;
                    end else if (i_cpu_write) begin
                        if (i_cpu_addr == DMA_ADDR) begin
                            r_page      <= i_cpu_d_out;
                            r_cnt       <= 8'h00;
                            // Extra alignment cycle when the $4014 write cycle is odd.
                            r_align_cnt <= r_parity;
                            r_state     <= S_DMA_ALIGN;
                        end
                    end else if (w_cpu_ram) begin
                        r_d_in <= r_ram[w_ram_addr];
                    end else if (w_cpu_prg) begin
                        r_prg_pend <= 1'b1;
                    end
                end
                S_PPU_WAIT: begin
                    if (i_ppu_ack) begin
                        r_ppu_rd      <= i_ppu_rdata;
                        r_ppu_is_read <= ~i_cpu_write;
                        r_state       <= S_PPU_DONE;
                    end
                end
                S_PPU_DONE: begin
                    if (r_ppu_is_read) begin
                        r_d_in <= r_ppu_rd;
                    end
                    r_state <= S_IDLE;
                end
                S_DMA_ALIGN: begin
                    if (r_align_cnt == 1'b0) begin
                        r_state <= S_DMA_READ;
                    end else begin
                        r_align_cnt <= r_align_cnt - 1'b1;
                    end
                end
                S_DMA_READ: begin
                    r_dma_prg  <= w_dma_prg;
                    r_dma_byte <= w_dma_ram ? r_ram[w_ram_addr] : r_d_in;
                    r_state    <= S_DMA_WRITE;
                end
                S_DMA_WRITE: begin
                    if (i_ppu_ack) begin
                        if (r_cnt == 8'hFF) begin
                            r_cnt   <= 8'h00;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                            r_state <= S_DMA_READ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from the registered state; reset forces the idle values
    // in the same cycle so an outstanding request drops immediately.
    always_comb begin
        o_cpu_d_in  = r_prg_pend ? i_prg_data : r_d_in;
        o_cpu_ready = 1'b1;
        o_prg_addr  = i_cpu_addr[14:0];
        o_ppu_req   = 1'b0;
        o_ppu_we    = 1'b0;
        o_ppu_reg   = 3'd0;
        o_ppu_wdata = 8'h00;
        case (r_state)
            S_IDLE:      o_cpu_ready = !w_cpu_ppu;
            S_PPU_WAIT: begin
                o_cpu_ready = 1'b0;
                o_ppu_req   = 1'b1;
                o_ppu_we    = i_cpu_write;
                o_ppu_reg   = i_cpu_addr[2:0];
                o_ppu_wdata = i_cpu_d_out;
            end
            S_PPU_DONE:  o_cpu_ready = 1'b1;
            S_DMA_ALIGN: o_cpu_ready = 1'b0;
            S_DMA_READ: begin
                o_cpu_ready = 1'b0;
                o_prg_addr  = w_dma_addr[14:0];
            end
            S_DMA_WRITE: begin
                o_cpu_ready = 1'b0;
                o_prg_addr  = w_dma_addr[14:0];
                o_ppu_req   = 1'b1;
                o_ppu_we    = 1'b1;
                o_ppu_reg   = OAM_DATA_REG;
                o_ppu_wdata = w_dma_data;
            end
            default:     o_cpu_ready = 1'b1;
        endcase
        if (i_reset) begin
            o_cpu_d_in  = 8'h00;
            o_cpu_ready = 1'b1;
            o_prg_addr  = 15'd0;
            o_ppu_req   = 1'b0;
            o_ppu_we    = 1'b0;
            o_ppu_reg   = 3'd0;
            o_ppu_wdata = 8'h00;
        end
    end

endmodule
